// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
//
// Shared types and constants for the 1:8 TDM demultiplexer.
//   N_SLOTS  : slots per frame
//   SLOT_W   : width of the slot index
//   MISS_W   : width of the consecutive-missing-sync counter (limit up to 7)
//   state_t  : frame-lock FSM states
//   slot_op_t / miss_op_t : commands from the top-level FSM to tdm_slot_ctr
//   beat_t   : classification of the current input beat, decoded once and
//              shared by the next-state and output logic
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int N_SLOTS = 8;
    localparam int SLOT_W  = 3;
    localparam int MISS_W  = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_INC   = 2'd1,
        SLOT_LOAD1 = 2'd2,
        SLOT_CLEAR = 2'd3
    } slot_op_t;

    typedef enum logic [1:0] {
        MISS_HOLD  = 2'd0,
        MISS_INC   = 2'd1,
        MISS_CLEAR = 2'd2
    } miss_op_t;

    // What the current beat means for the frame in progress.
    typedef enum logic [2:0] {
        BEAT_IDLE     = 3'd0,  // no valid beat, or a discarded beat in HUNT
        BEAT_SYNC     = 3'd1,  // sync marker where slot 0 is expected
        BEAT_SYNC_ERR = 3'd2,  // sync marker in the middle of a frame
        BEAT_FLY      = 3'd3,  // slot 0 without marker, still within tolerance
        BEAT_LOSS     = 3'd4,  // slot 0 without marker, tolerance exhausted
        BEAT_DATA     = 3'd5,  // slots 1..6
        BEAT_LAST     = 3'd6   // slot 7, completes the frame
    } beat_t;

    // True when one more missing marker reaches the loss threshold.
    function automatic logic miss_limit_hit(input logic [MISS_W-1:0] cnt,
                                            input int limit);
        return (int'(cnt) + 1) >= limit;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
//
// Slot position and flywheel miss counter for the TDM demultiplexer.
// The owning FSM issues one command per counter per cycle; HOLD keeps value.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (both counters to 0)
//   slot_op  in   slot command: hold / increment (7 wraps to 0) / load 1 / clear
//   miss_op  in   miss command: hold / increment / clear
//   slot     out  index the next valid beat will occupy
//   miss_cnt out  consecutive frames started without a sync marker
// -----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        slot_op,
    input  logic [1:0]        miss_op,
    output logic [SLOT_W-1:0] slot,
    output logic [MISS_W-1:0] miss_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else begin
            case (slot_op)
                SLOT_INC:   slot <= slot + 1'b1;  // natural wrap 7 -> 0
                SLOT_LOAD1: slot <= SLOT_W'(1);
                SLOT_CLEAR: slot <= '0;
                default:    slot <= slot;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt <= '0;
        end else begin
            case (miss_op)
                MISS_INC:   miss_cnt <= miss_cnt + 1'b1;
                MISS_CLEAR: miss_cnt <= '0;
                default:    miss_cnt <= miss_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux_1_8.sv
// -----------------------------------------------------------------------------
// tdm_demux_1_8
//
// Receive side of an 8-slot TDM link. Locks onto the slot-0 sync marker,
// gathers slots 0..6 in a shadow register and, on the slot-7 beat, presents
// the whole frame on q at once together with a one-cycle q_vld pulse.
// While locked, frames lacking a marker are carried by a flywheel until
// MISS_LIMIT consecutive markers are missing, then the receiver re-hunts.
//
// Parameters:
//   WIDTH      data bits per slot
//   MISS_LIMIT consecutive missing markers before lock is dropped (1..7)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   din       in   slot data
//   din_vld   in   beat qualifier; nothing changes while low
//   din_sync  in   marks the beat as slot 0 (only meaningful with din_vld)
//   q         out  last complete frame, slot k at q[k*WIDTH +: WIDTH]
//   q_vld     out  one-cycle pulse with each new q
//   locked    out  high while in RUN
//   sync_err  out  one-cycle pulse on a marker in the middle of a frame
//   slot      out  index the next valid beat will occupy
//
// Handshake: din is consumed on every cycle din_vld is high (no backpressure);
// q/q_vld is a pure pulse, the consumer must take q while q_vld is high or
// read the held value later.
// -----------------------------------------------------------------------------
module tdm_demux_1_8
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_vld,
    input  logic                     din_sync,
    output logic [N_SLOTS*WIDTH-1:0] q,
    output logic                     q_vld,
    output logic                     locked,
    output logic                     sync_err,
    output logic [SLOT_W-1:0]        slot
);

    state_t              state;
    state_t              state_nxt;
    beat_t               beat;
    slot_op_t            slot_op;
    miss_op_t            miss_op;
    logic [MISS_W-1:0]   miss_cnt;

    logic                shadow_we;
    logic [SLOT_W-1:0]   shadow_idx;
    logic                frame_done;
    logic                err;

    // Slot 7 never lands in the shadow: it is merged straight into q on the
    // edge that samples it, so only slots 0..6 need storage.
    logic [(N_SLOTS-1)*WIDTH-1:0] shadow;

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .slot_op  (slot_op),
        .miss_op  (miss_op),
        .slot     (slot),
        .miss_cnt (miss_cnt)
    );

    // Classify the current beat once; both FSM processes key off this.
    always_comb begin
        beat = BEAT_IDLE;
        if (din_vld) begin
            if (state == HUNT) begin
                if (din_sync) beat = BEAT_SYNC;
            end else if (din_sync) begin
                beat = (slot == '0) ? BEAT_SYNC : BEAT_SYNC_ERR;
            end else if (slot == '0) begin
                beat = miss_limit_hit(miss_cnt, MISS_LIMIT) ? BEAT_LOSS : BEAT_FLY;
            end else if (slot == SLOT_W'(N_SLOTS - 1)) begin
                beat = BEAT_LAST;
            end else begin
                beat = BEAT_DATA;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (beat == BEAT_SYNC) state_nxt = RUN;
            RUN:     if (beat == BEAT_LOSS) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    // FSM: outputs and datapath commands
    always_comb begin
        locked     = (state == RUN);
        slot_op    = SLOT_HOLD;
        miss_op    = MISS_HOLD;
        shadow_we  = 1'b0;
        shadow_idx = slot;
        frame_done = 1'b0;
        err        = 1'b0;
        case (beat)
            BEAT_SYNC: begin
                slot_op    = SLOT_LOAD1;
                miss_op    = MISS_CLEAR;
                shadow_we  = 1'b1;
                shadow_idx = '0;
            end
            BEAT_SYNC_ERR: begin
                // The partial frame is abandoned simply by restarting at
                // slot 1; its shadow entries are overwritten before q uses them.
                slot_op    = SLOT_LOAD1;
                miss_op    = MISS_CLEAR;
                shadow_we  = 1'b1;
                shadow_idx = '0;
                err        = 1'b1;
            end
            BEAT_FLY: begin
                slot_op    = SLOT_LOAD1;
                miss_op    = MISS_INC;
                shadow_we  = 1'b1;
                shadow_idx = '0;
            end
            BEAT_LOSS: begin
                slot_op = SLOT_CLEAR;
                miss_op = MISS_CLEAR;
            end
            BEAT_DATA: begin
                slot_op   = SLOT_INC;
                shadow_we = 1'b1;
            end
            BEAT_LAST: begin
                slot_op    = SLOT_INC;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadow and output registers. q only changes on a completed frame, so it
    // keeps the last good frame through gaps, resync and loss of lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            q        <= '0;
            q_vld    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            q_vld    <= frame_done;
            sync_err <= err;
            if (shadow_we) begin
                shadow[int'(shadow_idx)*WIDTH +: WIDTH] <= din;
            end
            if (frame_done) begin
                q <= {din, shadow};
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1_8
//
// Directed bench for tdm_demux_1_8 with WIDTH=1, MISS_LIMIT=2. Inputs change
// 1 time unit after the rising edge; outputs are checked at that same point,
// i.e. they show the values registered by the edge just passed.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1_8;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic       din_vld;
    logic       din_sync;
    logic [7:0] q;
    logic       q_vld;
    logic       locked;
    logic       sync_err;
    logic [2:0] slot;

    int n_vec;
    int n_err;
    int cyc;
    int pulse_q[$];

    tdm_demux_1_8 #(
        .WIDTH      (1),
        .MISS_LIMIT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_sync (din_sync),
        .q        (q),
        .q_vld    (q_vld),
        .locked   (locked),
        .sync_err (sync_err),
        .slot     (slot)
    );

    // clock / cycle counter / q_vld pulse log
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (q_vld === 1'b1) pulse_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_q, input logic e_qv,
                           input logic e_lk, input logic e_se, input logic [2:0] e_slot);
        chk({tag, "/q"},        32'(q),        32'(e_q));
        chk({tag, "/q_vld"},    32'(q_vld),    32'(e_qv));
        chk({tag, "/locked"},   32'(locked),   32'(e_lk));
        chk({tag, "/sync_err"}, 32'(sync_err), 32'(e_se));
        chk({tag, "/slot"},     32'(slot),     32'(e_slot));
    endtask

    task automatic beat(input logic v, input logic s, input logic d);
        din_vld  = v;
        din_sync = s;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    // Full frame while lock is held (or acquired on beat 0); prev_q is the
    // frame expected on q until the last beat lands.
    task automatic send_frame(input string tag, input logic [7:0] f,
                              input logic sync0, input logic [7:0] prev_q);
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, sync0 && (k == 0), f[k]);
            chk_out($sformatf("%s.b%0d", tag, k), (k == 7) ? f : prev_q,
                    (k == 7), 1'b1, 1'b0, 3'((k + 1) % 8));
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        rst      = 1'b1;
        din      = '0;
        din_vld  = 1'b0;
        din_sync = 1'b0;

        // reset values
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;

        // beat without sync is discarded while hunting
        beat(1'b1, 1'b0, 1'b1);
        chk_out("hunt_discard", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // lock on first frame: data 1,0,1,1,0,0,1,0 -> 8'h4D
        send_frame("lock", 8'h4D, 1'b1, 8'h00);
        beat(1'b0, 1'b0, 1'b0);
        chk_out("lock_idle", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd0);

        // gapped frame 8'hB2: 3 idle cycles between slots 3 and 4,
        // one of them carrying a stray sync without din_vld
        for (int k = 0; k < 4; k++) beat(1'b1, (k == 0), 1'(8'hB2 >> k));
        chk_out("gap_pre", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd4);
        beat(1'b0, 1'b0, 1'b1);
        chk_out("gap_c0", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd4);
        beat(1'b0, 1'b1, 1'b1);
        chk_out("gap_c1", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd4);
        beat(1'b0, 1'b0, 1'b0);
        chk_out("gap_c2", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd4);
        for (int k = 4; k < 7; k++) beat(1'b1, 1'b0, 1'(8'hB2 >> k));
        chk_out("gap_s6", 8'h4D, 1'b0, 1'b1, 1'b0, 3'd7);
        beat(1'b1, 1'b0, 1'b1);
        chk_out("gap_last", 8'hB2, 1'b1, 1'b1, 1'b0, 3'd0);
        beat(1'b0, 1'b0, 1'b0);
        chk_out("gap_idle", 8'hB2, 1'b0, 1'b1, 1'b0, 3'd0);

        // early sync at slot 5: sync_err pulse, partial frame dropped
        beat(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) beat(1'b1, 1'b0, 1'b1);
        chk_out("early_pre", 8'hB2, 1'b0, 1'b1, 1'b0, 3'd5);
        beat(1'b1, 1'b1, 1'b1);
        chk_out("early_sync", 8'hB2, 1'b0, 1'b1, 1'b1, 3'd1);
        // resynced frame: slot0=1 above, slots 1..7 = 0,1,1,0,0,1,0 -> 8'h4D
        beat(1'b1, 1'b0, 1'b0);
        chk_out("early_s1", 8'hB2, 1'b0, 1'b1, 1'b0, 3'd2);
        for (int k = 2; k < 7; k++) beat(1'b1, 1'b0, 1'(8'h4D >> k));
        chk_out("early_s6", 8'hB2, 1'b0, 1'b1, 1'b0, 3'd7);
        beat(1'b1, 1'b0, 1'b0);
        chk_out("early_last", 8'h4D, 1'b1, 1'b1, 1'b0, 3'd0);

        // flywheel: one frame without sync still decodes
        send_frame("fly", 8'h5A, 1'b0, 8'h4D);
        // second consecutive miss: beat dropped, lock lost, q kept
        beat(1'b1, 1'b0, 1'b1);
        chk_out("loss", 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) beat(1'b1, 1'b0, 1'b1);
        chk_out("loss_hunt", 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0);

        // reset mid-frame at slot 4
        for (int k = 0; k < 4; k++) beat(1'b1, (k == 0), 1'b1);
        chk_out("mrst_pre", 8'h5A, 1'b0, 1'b1, 1'b0, 3'd4);
        rst = 1'b1;
        beat(1'b1, 1'b0, 1'b1);
        chk_out("mrst_edge", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        for (int k = 5; k < 8; k++) beat(1'b1, 1'b0, 1'b1);
        chk_out("mrst_after", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

        // back-to-back frames at full rate
        pulse_q.delete();
        send_frame("b2b0", 8'hC3, 1'b1, 8'h00);
        send_frame("b2b1", 8'h96, 1'b1, 8'hC3);
        send_frame("b2b2", 8'h01, 1'b1, 8'h96);
        send_frame("b2b3", 8'hFE, 1'b1, 8'h01);
        beat(1'b0, 1'b0, 1'b0);
        chk_out("b2b_idle", 8'hFE, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("b2b_pulses", 32'(pulse_q.size()), 32'd4);
        for (int i = 1; i < pulse_q.size(); i++) begin
            chk($sformatf("b2b_gap%0d", i), 32'(pulse_q[i] - pulse_q[i-1]), 32'd8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1_8.md
# tdm_demux_1_8

Receive-side counterpart of the 8:1 selector path: takes a time-division-multiplexed stream of 8 slots per frame, locks onto a frame-sync marker, and distributes each slot to one of 8 registered outputs. Slots accumulate in a shadow register and are presented atomically once per complete frame. It sits at the far end of a link whose transmitter scans slots 0..7 in order through a selector.

## Interface
- WIDTH, 1, data bits per slot
- MISS_LIMIT, 2, consecutive missing sync markers at slot 0 before lock is dropped (range 1..7)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  WIDTH  slot data
- din_vld  in  1  beat qualifier; all state holds when low
- din_sync  in  1  marks the current beat as slot 0; ignored when din_vld is low
- q  out  8*WIDTH  frame output; slot k at q[k*WIDTH +: WIDTH]
- q_vld  out  1  one-cycle pulse, coincident with new q
- locked  out  1  high while in RUN
- sync_err  out  1  one-cycle pulse on an unexpected sync marker
- slot  out  3  index the next valid beat will occupy

## Operation
- States: HUNT, RUN. Reset → HUNT.
- Reset values: q=0, q_vld=0, locked=0, sync_err=0, slot=0, shadow=0, miss_cnt=0.
- HUNT: beats without sync are discarded. Beat with din_sync → shadow[0]=din, slot=1, miss_cnt=0, go RUN.
- RUN, valid beat, slot in 1..6, no sync: shadow[slot]=din, slot+1.
- RUN, valid beat, slot=7, no sync: q={din, shadow[6:0]}, q_vld=1 next cycle, slot wraps to 0.
- RUN, valid beat, slot=0, sync: shadow[0]=din, miss_cnt=0, slot=1.
- RUN, valid beat, slot=0, no sync (flywheel): miss_cnt+1. If the new count is below MISS_LIMIT, accept the beat as slot 0 and set slot=1. If it equals MISS_LIMIT, discard the beat, go HUNT, set slot=0 and miss_cnt=0.
- RUN, valid beat with sync, slot≠0: sync_err=1 for one cycle. The partial frame is discarded with no q update. The beat is taken as slot 0: shadow[0]=din, slot=1, miss_cnt=0. Remains in RUN.
- din_vld low: no state, shadow, slot, or q change; q_vld and sync_err go low.
- q holds its last frame between updates, including across loss of lock. Only reset clears q.
- Shadow entries are not cleared between frames. Every frame writes all 8 slots before q updates, so stale data never reaches q.

## Timing
- Output latency: q and q_vld are updated at the same edge that samples the slot-7 beat. q_vld is high for exactly the following cycle.
- Back-to-back frames at full rate produce q_vld once every 8 cycles. There is no throughput loss at the wrap.
- locked rises the cycle after the first sync beat is sampled. It falls the cycle after the MISS_LIMIT-th miss is sampled.
- slot is registered and reflects the post-edge value. In HUNT, slot reads 0.
- Reset asserted mid-frame: all registers take reset values at that edge and the partial frame is lost. The first beat after reset deasserts is evaluated in HUNT.
- din_sync with din_vld low has no effect in any state.

## Structure
- Package tdm_demux_pkg: N_SLOTS=8, SLOT_W=3, state enum {HUNT, RUN}.
- One natural sub-module, tdm_slot_ctr. It holds the 3-bit slot counter with inc, load-to-1, clear and wrap, plus the miss counter. The top level holds the FSM, shadow, and the output registers.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset then lock: apply reset, then a sync beat followed by 7 beats with data 1,0,1,1,0,0,1,0, WIDTH=1 → q=8'b0100_1101 (slot 0 at LSB) and q_vld high for 1 cycle the cycle after the 8th beat; locked=1 from the 2nd cycle.
- Gapped input: same frame with din_vld low for 3 cycles between slots 3 and 4 → identical q, with q_vld delayed by 3 cycles; slot holds at 4 through the gap.
- Early sync: sync asserted at slot 5 → sync_err pulses once, no q_vld for the partial frame, slot=1 after that beat, and the next full frame updates q correctly.
- Flywheel and loss, MISS_LIMIT=2: one frame without sync → still decoded with q_vld and locked=1. Second consecutive frame without sync → that beat is discarded, locked=0, slot=0, and q keeps the previous frame.
- Reset mid-frame: assert rst at slot 4 of a frame → q=0, locked=0 the next cycle, no q_vld; the remaining beats are ignored until a sync beat arrives.
- Back-to-back stream: 4 consecutive frames with continuous din_vld → 4 q_vld pulses exactly 8 cycles apart, each q matching its frame.
